main_fsm: RTL and testbench
===========================

# main_fsm

Multi-cycle main control state machine for the RISC-V core. It sequences each instruction through fetch, decode, execute, memory and writeback states, and produces the datapath enables and mux selects. It also drives the 2-bit ALUOp consumed directly by the ALU decoder, `aludec`. It reads the 7-bit opcode from the instruction register and sits beside `aludec` inside the controller top.

## Interface
Parameters: none. Opcodes, encodings and state type come from the shared package.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset, asynchronous and active-low; forces state FETCH.
- i_op  in  7  opcode, instr[6:0], from the instruction register (stable outside FETCH).
- i_mem_ready  in  1  memory completion for the current access.
- o_aluop  out  2  to aludec: 00 add, 01 sub/branch, 10 funct-decoded.
- o_alusrca  out  2  00 PC, 01 OldPC, 10 rs1.
- o_alusrcb  out  2  00 rs2, 01 imm, 10 constant 4.
- o_resultsrc  out  2  00 ALUOut, 01 read data, 10 ALU result.
- o_adrsrc  out  1  0 PC, 1 Result (data address).
- o_irwrite  out  1  instruction register / OldPC load.
- o_pcupdate  out  1  unconditional PC write.
- o_branch  out  1  PC write qualified by Zero (AND done outside).
- o_regwrite  out  1  register file write.
- o_memwrite  out  1  data memory write request.
- o_illegal  out  1  unsupported opcode seen in DECODE.
- o_state  out  4  current state, for debug and verification.

## Operation
Outputs are Moore decodes of the state. The exceptions are the i_mem_ready qualifiers and o_illegal. Any field not listed for a state is 0.

States and outputs:
- FETCH: adrsrc=0, alusrca=00, alusrcb=10, aluop=00, resultsrc=10. irwrite=pcupdate=i_mem_ready.
- DECODE: alusrca=01, alusrcb=01, aluop=00 (branch target into ALUOut). o_illegal=1 if opcode unsupported.
- MEMADR: alusrca=10, alusrcb=01, aluop=00.
- MEMREAD: adrsrc=1, resultsrc=00.
- MEMWB: resultsrc=01, regwrite=1.
- MEMWRITE: adrsrc=1, resultsrc=00, memwrite=1 (held as a level until ready).
- EXECUTER: alusrca=10, alusrcb=00, aluop=10.
- EXECUTEI: alusrca=10, alusrcb=01, aluop=10.
- ALUWB: resultsrc=00, regwrite=1.
- BEQ: alusrca=10, alusrcb=00, aluop=01, resultsrc=00, branch=1.
- JAL: alusrca=01, alusrcb=10, aluop=00, resultsrc=00, pcupdate=1.

Transitions:
- FETCH -> DECODE when i_mem_ready; otherwise stay.
- DECODE dispatches on i_op:
  - 0000011 (lw) or 0100011 (sw) -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - anything else -> FETCH
- MEMADR -> MEMREAD for lw, MEMWRITE for sw.
- MEMREAD -> MEMWB when ready; otherwise stay.
- MEMWRITE -> FETCH when ready; otherwise stay.
- EXECUTER, EXECUTEI, JAL -> ALUWB.
- MEMWB, ALUWB, BEQ -> FETCH.
- Any unreachable encoding -> FETCH.

## Timing
- Reset: state=FETCH immediately, asynchronously.
  - While i_rst_n=0: o_aluop=00, o_alusrca=00, o_alusrcb=10, o_resultsrc=10, o_adrsrc=0, o_state=FETCH.
  - All other outputs 0, except irwrite/pcupdate, which follow i_mem_ready.
- First edge after deassertion evaluates the FETCH transition.
- Latency with i_mem_ready=1:
  - R/I-type: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq: 3 cycles
  - jal: 4 cycles
  - illegal: 2 cycles
- Each cycle with i_mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. irwrite/pcupdate pulse exactly once per fetch.
- i_op is sampled only in DECODE and MEMADR.
- Reset mid-instruction aborts it; no write enable may be asserted after reset assertion.

## Structure
- Shared package riscv_ctrl_pkg:
  - state enum `state_t` (4-bit)
  - opcode localparams
  - ALUOp, ALUSrcA/B and ResultSrc encodings
  - aludec also uses this package.
- Single module, no sub-module: one state register and combinational next-state/output logic. The controller top instantiates main_fsm, aludec and the branch AND.

## Test plan
- Reset with i_rst_n=0 mid-EXECUTER -> o_state=FETCH immediately, alusrcb=10, regwrite=0. After release with ready=1, irwrite=1 on the first cycle.
- i_op=0110011, ready=1 -> states FETCH, DECODE, EXECUTER, ALUWB, FETCH. aluop=10 in EXECUTER; regwrite=1 only in ALUWB.
- lw (0000011) with ready low for 2 cycles in MEMREAD -> MEMREAD held 3 cycles. regwrite=1 in MEMWB with resultsrc=01; total 7 cycles.
- sw (0100011), ready=0 for 3 cycles in FETCH -> irwrite/pcupdate asserted in exactly one cycle. memwrite=1 in MEMWRITE, adrsrc=1, regwrite never 1.
- beq (1100011) -> DECODE aluop=00/alusrca=01; BEQ branch=1, aluop=01. Back in FETCH after 3 cycles.
- i_op=1111111 -> o_illegal=1 for one cycle in DECODE, next state FETCH, no write enables asserted.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared control definitions for the multi-cycle RISC-V controller.
// Used by main_fsm and aludec.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/main_fsm.sv
// Multi-cycle main control FSM: sequences fetch/decode/execute/memory/writeback
// and decodes datapath enables and mux selects from the current state.
module main_fsm
  import riscv_ctrl_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [6:0] i_op,
  input  logic       i_mem_ready,
  output logic [1:0] o_aluop,
  output logic [1:0] o_alusrca,
  output logic [1:0] o_alusrcb,
  output logic [1:0] o_resultsrc,
  output logic       o_adrsrc,
  output logic       o_irwrite,
  output logic       o_pcupdate,
  output logic       o_branch,
  output logic       o_regwrite,
  output logic       o_memwrite,
  output logic       o_illegal,
  output logic [3:0] o_state
);

  state_t state_q, state_d;

  // NOTE: state flops use non-blocking assignment so every flop samples
  // pre-edge values; reset is asynchronous so it acts without a clock.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  // NOTE: every signal written below gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = S_FETCH;
    o_aluop     = ALUOP_ADD;
    o_alusrca   = SRCA_PC;
    o_alusrcb   = SRCB_RS2;
    o_resultsrc = RES_ALUOUT;
    o_adrsrc    = 1'b0;
    o_irwrite   = 1'b0;
    o_pcupdate  = 1'b0;
    o_branch    = 1'b0;
    o_regwrite  = 1'b0;
    o_memwrite  = 1'b0;
    o_illegal   = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        o_alusrcb   = SRCB_FOUR;
        o_resultsrc = RES_ALU;
        o_irwrite   = i_mem_ready;
        o_pcupdate  = i_mem_ready;
        state_d     = i_mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // ALU precomputes the branch target into ALUOut.
        o_alusrca = SRCA_OLDPC;
        o_alusrcb = SRCB_IMM;
        case (i_op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTER;
          OP_ITYPE:     state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin
            state_d   = S_FETCH;
            o_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        o_alusrca = SRCA_RS1;
        o_alusrcb = SRCB_IMM;
        if (i_op == OP_LW)      state_d = S_MEMREAD;
        else if (i_op == OP_SW) state_d = S_MEMWRITE;
        else                    state_d = S_FETCH;
      end
      S_MEMREAD: begin
        o_adrsrc = 1'b1;
        state_d  = i_mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        o_resultsrc = RES_RDATA;
        o_regwrite  = 1'b1;
      end
      S_MEMWRITE: begin
        o_adrsrc   = 1'b1;
        o_memwrite = 1'b1;
        state_d    = i_mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        o_alusrca = SRCA_RS1;
        o_aluop   = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_EXECUTEI: begin
        o_alusrca = SRCA_RS1;
        o_alusrcb = SRCB_IMM;
        o_aluop   = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: o_regwrite = 1'b1;
      S_BEQ: begin
        o_alusrca = SRCA_RS1;
        o_aluop   = ALUOP_SUB;
        o_branch  = 1'b1;
      end
      S_JAL: begin
        o_alusrca  = SRCA_OLDPC;
        o_alusrcb  = SRCB_FOUR;
        o_pcupdate = 1'b1;
        state_d    = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign o_state = state_q;

endmodule

// File: tb/tb_main_fsm.sv
// Directed bench for main_fsm: a per-cycle scoreboard of expected state and
// outputs is filled instruction by instruction, then drained against the DUT.
module tb_main_fsm;
  import riscv_ctrl_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [6:0] op;
  logic       mem_ready;
  logic [1:0] aluop, alusrca, alusrcb, resultsrc;
  logic       adrsrc, irwrite, pcupdate, branch, regwrite, memwrite, illegal;
  logic [3:0] state;

  main_fsm dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_op        (op),
    .i_mem_ready (mem_ready),
    .o_aluop     (aluop),
    .o_alusrca   (alusrca),
    .o_alusrcb   (alusrcb),
    .o_resultsrc (resultsrc),
    .o_adrsrc    (adrsrc),
    .o_irwrite   (irwrite),
    .o_pcupdate  (pcupdate),
    .o_branch    (branch),
    .o_regwrite  (regwrite),
    .o_memwrite  (memwrite),
    .o_illegal   (illegal),
    .o_state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected summary");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic       rst_n;
    logic       rdy;
    logic [6:0] op;
    logic [3:0] exp_state;
    logic [14:0] exp_out;
    string      tag;
  } step_t;

  step_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Expected outputs straight from the state/output table:
  // {aluop, alusrca, alusrcb, resultsrc, adrsrc, irwrite, pcupdate, branch, regwrite, memwrite, illegal}
  function automatic logic [14:0] model(state_t s, logic rdy, logic [6:0] o);
    logic [1:0] a_op = 2'b00, sa = 2'b00, sb_ = 2'b00, rs = 2'b00;
    logic adr = 0, ir = 0, pcu = 0, br = 0, rw = 0, mw = 0, ill = 0;
    case (s)
      S_FETCH:    begin sb_ = 2'b10; rs = 2'b10; ir = rdy; pcu = rdy; end
      S_DECODE:   begin
        sa = 2'b01; sb_ = 2'b01;
        ill = !(o inside {7'b0000011, 7'b0100011, 7'b0110011,
                          7'b0010011, 7'b1100011, 7'b1101111});
      end
      S_MEMADR:   begin sa = 2'b10; sb_ = 2'b01; end
      S_MEMREAD:  adr = 1;
      S_MEMWB:    begin rs = 2'b01; rw = 1; end
      S_MEMWRITE: begin adr = 1; mw = 1; end
      S_EXECUTER: begin sa = 2'b10; a_op = 2'b10; end
      S_EXECUTEI: begin sa = 2'b10; sb_ = 2'b01; a_op = 2'b10; end
      S_ALUWB:    rw = 1;
      S_BEQ:      begin sa = 2'b10; a_op = 2'b01; br = 1; end
      S_JAL:      begin sa = 2'b01; sb_ = 2'b10; pcu = 1; end
      default:    ;
    endcase
    return {a_op, sa, sb_, rs, adr, ir, pcu, br, rw, mw, ill};
  endfunction

  task automatic push(input state_t s, input logic rdy, input logic [6:0] o,
                      input logic rst, input string tag);
    step_t e;
    e.rst_n = rst; e.rdy = rdy; e.op = o; e.exp_state = s;
    e.exp_out = model(s, rdy, o); e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic check(input string tag, input logic [14:0] obs, input logic [14:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's stimulus at the falling edge and compare 1 time unit later.
  task automatic drain();
    step_t e;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      @(negedge clk);
      rst_n = e.rst_n; mem_ready = e.rdy; op = e.op;
      #1;
      check({e.tag, ".state"}, {11'd0, state}, {11'd0, e.exp_state});
      check({e.tag, ".outs"},
            {aluop, alusrca, alusrcb, resultsrc, adrsrc, irwrite, pcupdate,
             branch, regwrite, memwrite, illegal},
            e.exp_out);
    end
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; op = 7'b0110011;

    // Held in reset: FETCH decode, irwrite/pcupdate follow ready.
    push(S_FETCH, 0, 7'b0110011, 0, "rst_rdy0");
    push(S_FETCH, 1, 7'b0110011, 0, "rst_rdy1");
    // R-type
    push(S_FETCH,    1, 7'b0110011, 1, "r.fetch");
    push(S_DECODE,   1, 7'b0110011, 1, "r.decode");
    push(S_EXECUTER, 1, 7'b0110011, 1, "r.exec");
    push(S_ALUWB,    1, 7'b0110011, 1, "r.wb");
    // I-type
    push(S_FETCH,    1, 7'b0010011, 1, "i.fetch");
    push(S_DECODE,   1, 7'b0010011, 1, "i.decode");
    push(S_EXECUTEI, 1, 7'b0010011, 1, "i.exec");
    push(S_ALUWB,    1, 7'b0010011, 1, "i.wb");
    // lw with two wait cycles in MEMREAD: 7 cycles total
    push(S_FETCH,   1, 7'b0000011, 1, "lw.fetch");
    push(S_DECODE,  1, 7'b0000011, 1, "lw.decode");
    push(S_MEMADR,  1, 7'b0000011, 1, "lw.memadr");
    push(S_MEMREAD, 0, 7'b0000011, 1, "lw.rd_wait0");
    push(S_MEMREAD, 0, 7'b0000011, 1, "lw.rd_wait1");
    push(S_MEMREAD, 1, 7'b0000011, 1, "lw.rd_done");
    push(S_MEMWB,   1, 7'b0000011, 1, "lw.wb");
    // sw with three fetch stalls and one write stall
    push(S_FETCH,    0, 7'b0100011, 1, "sw.fetch_wait0");
    push(S_FETCH,    0, 7'b0100011, 1, "sw.fetch_wait1");
    push(S_FETCH,    0, 7'b0100011, 1, "sw.fetch_wait2");
    push(S_FETCH,    1, 7'b0100011, 1, "sw.fetch");
    push(S_DECODE,   1, 7'b0100011, 1, "sw.decode");
    push(S_MEMADR,   1, 7'b0100011, 1, "sw.memadr");
    push(S_MEMWRITE, 0, 7'b0100011, 1, "sw.wr_wait");
    push(S_MEMWRITE, 1, 7'b0100011, 1, "sw.wr_done");
    // beq
    push(S_FETCH,  1, 7'b1100011, 1, "beq.fetch");
    push(S_DECODE, 1, 7'b1100011, 1, "beq.decode");
    push(S_BEQ,    1, 7'b1100011, 1, "beq.branch");
    // jal
    push(S_FETCH,  1, 7'b1101111, 1, "jal.fetch");
    push(S_DECODE, 1, 7'b1101111, 1, "jal.decode");
    push(S_JAL,    1, 7'b1101111, 1, "jal.jump");
    push(S_ALUWB,  1, 7'b1101111, 1, "jal.wb");
    // illegal opcode: one DECODE cycle flagged, then back to FETCH
    push(S_FETCH,  1, 7'b1111111, 1, "ill.fetch");
    push(S_DECODE, 1, 7'b1111111, 1, "ill.decode");
    // R-type aborted by asynchronous reset in EXECUTER, then rerun
    push(S_FETCH,    1, 7'b0110011, 1, "abort.fetch");
    push(S_DECODE,   1, 7'b0110011, 1, "abort.decode");
    push(S_EXECUTER, 1, 7'b0110011, 1, "abort.exec");
    push(S_FETCH,    1, 7'b0110011, 0, "abort.reset");
    push(S_FETCH,    1, 7'b0110011, 1, "rerun.fetch");
    push(S_DECODE,   1, 7'b0110011, 1, "rerun.decode");
    push(S_EXECUTER, 1, 7'b0110011, 1, "rerun.exec");
    push(S_ALUWB,    1, 7'b0110011, 1, "rerun.wb");
    push(S_FETCH,    0, 7'b0110011, 1, "final.fetch_idle");

    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
